// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, canonical NOP,
// the fetch-buffer entry record and the PC+4 helper.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;

    // Sequential PC, wrapping modulo 2^XLEN
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// Storage array for the IF/ID buffer: DEPTH fetch entries, one synchronous
// write port and one asynchronous read port. Contents are never reset;
// validity is tracked entirely by the pointers in the parent.
module if_id_fifo_mem
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_entry_t     wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_entry_t     rdata
);

    fetch_entry_t mem [DEPTH];

    // Write the addressed slot on an accepted push
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID instruction buffer: a small FIFO of {PC, instruction} pairs between
// fetch and decode with valid/ready handshakes. fetch_ready gates the PC
// counter so the PC holds while the buffer is full; flush discards all
// buffered entries on a redirect.
// Optional feature: define IF_ID_BYPASS_EN for a zero-latency combinational
// pass-through from fetch_* to id_* while the buffer is empty.
module if_id_buffer #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_valid,
    input  logic [XLEN-1:0]          fetch_pc,
    input  logic [XLEN-1:0]          fetch_instr,
    output logic                     fetch_ready,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_instr,
    output logic [XLEN-1:0]          id_pc_plus4,
    output logic                     id_misaligned,
    output logic [$clog2(DEPTH):0]   count
);

    import riscv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty       = (count == '0);
    // Registered state only: decode stalls never ripple into the PC enable
    assign fetch_ready = (count < CNT_W'(DEPTH));

`ifdef IF_ID_BYPASS_EN
    assign bypass = empty && fetch_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction consumed by decode in the same cycle is not stored
    assign push = fetch_valid && fetch_ready && !flush && !(bypass && id_ready);
    assign pop  = !empty && id_ready && !flush;

    assign wr_entry.pc         = fetch_pc;
    assign wr_entry.instr      = fetch_instr;
    assign wr_entry.misaligned = (fetch_pc[1:0] != 2'b00);

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy tracking; flush outranks push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode-side view: head entry, bypassed fetch, or NOP when empty
    always_comb begin
        id_valid      = 1'b0;
        id_pc         = '0;
        id_instr      = NOP_INSTR;
        id_misaligned = 1'b0;
        if (!empty) begin
            id_valid      = 1'b1;
            id_pc         = head.pc;
            id_instr      = head.instr;
            id_misaligned = head.misaligned;
        end else if (bypass) begin
            id_valid      = 1'b1;
            id_pc         = fetch_pc;
            id_instr      = fetch_instr;
            id_misaligned = wr_entry.misaligned;
        end
    end

    assign id_pc_plus4 = pc_plus4(id_pc);

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer (default build, 1-cycle latency).
// A vector table drives one cycle per record and checks occupancy/handshake
// outputs; a scoreboard queue holds every instruction the buffer should have
// accepted and checks each one as decode consumes it.
module tb_if_id_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_misaligned;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        idr;
        logic        fl;
        int          exp_cnt;
        logic        exp_fr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_instr   (fetch_instr),
        .fetch_ready   (fetch_ready),
        .flush         (flush),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .id_misaligned (id_misaligned),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[19:0], 12'h093};
    endfunction

    task automatic add(input logic fv, input logic [31:0] pc, input logic idr,
                       input logic fl, input int ec, input logic efr);
        vec_t v;
        v.fv = fv; v.pc = pc; v.instr = mk_instr(pc); v.idr = idr; v.fl = fl;
        v.exp_cnt = ec; v.exp_fr = efr;
        vecs.push_back(v);
    endtask

    // One cycle: drive just after posedge, check at negedge, update the model
    task automatic run_vec(input vec_t v, input int idx);
        sb_t e;
        string tag;
        fetch_valid = v.fv;
        fetch_pc    = v.pc;
        fetch_instr = v.instr;
        id_ready    = v.idr;
        flush       = v.fl;
        @(negedge clk);
        tag = $sformatf("v%0d", idx);
        chk({tag, ".count"},       32'(count),       32'(v.exp_cnt));
        chk({tag, ".fetch_ready"}, 32'(fetch_ready), 32'(v.exp_fr));
        chk({tag, ".id_valid"},    32'(id_valid),    32'(v.exp_cnt != 0));
        if (v.exp_cnt == 0) begin
            chk({tag, ".nop"}, id_instr, NOP);
            chk({tag, ".mis_empty"}, 32'(id_misaligned), 32'd0);
        end
        if (v.fl) begin
            sb.delete();
        end else begin
            if (id_valid && v.idr) begin
                if (sb.size() == 0) begin
                    chk({tag, ".unexpected_pop"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({tag, ".id_pc"},       id_pc,       e.pc);
                    chk({tag, ".id_instr"},    id_instr,    e.instr);
                    chk({tag, ".id_pc_plus4"}, id_pc_plus4, e.pc + 32'd4);
                    chk({tag, ".id_mis"},      32'(id_misaligned), 32'(e.pc[1:0] != 2'b00));
                end
            end
            // Accepted when the model holds fewer than DEPTH entries before the pop
            if (v.fv && v.exp_cnt < DEPTH) begin
                e.pc = v.pc; e.instr = v.instr;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        flush = 1'b0; id_ready = 1'b0;
        #12;
        chk("rst.count",       32'(count),         32'd0);
        chk("rst.id_valid",    32'(id_valid),      32'd0);
        chk("rst.id_pc",       id_pc,              32'd0);
        chk("rst.id_instr",    id_instr,           NOP);
        chk("rst.id_mis",      32'(id_misaligned), 32'd0);
        chk("rst.fetch_ready", 32'(fetch_ready),   32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single push, consumed next cycle
        add(1, 32'h0, 1, 0, 0, 1);
        vecs[0].instr = 32'h00500093;
        add(0, 32'h0, 1, 0, 1, 1);
        add(0, 32'h0, 0, 0, 0, 1);
        // fill while stalled, third offer refused, then drain in order
        add(1, 32'h0, 0, 0, 0, 1);
        add(1, 32'h4, 0, 0, 1, 1);
        add(1, 32'h8, 0, 0, 2, 0);
        add(1, 32'h8, 1, 0, 2, 0);
        add(1, 32'h8, 1, 0, 1, 1);
        add(0, 32'h0, 1, 0, 1, 1);
        add(0, 32'h0, 0, 0, 0, 1);
        // steady state: push and pop every cycle at count=1
        add(1, 32'h100, 0, 0, 0, 1);
        for (int k = 1; k <= 10; k++) add(1, 32'h100 + 32'(4 * k), 1, 0, 1, 1);
        add(0, 32'h0, 1, 0, 1, 1);
        add(0, 32'h0, 0, 0, 0, 1);
        // flush with a simultaneous offer at full
        add(1, 32'h20, 0, 0, 0, 1);
        add(1, 32'h24, 0, 0, 1, 1);
        add(1, 32'h40, 0, 1, 2, 0);
        add(0, 32'h0, 1, 0, 0, 1);
        // PC wrap and misaligned capture
        add(1, 32'hFFFFFFFC, 0, 0, 0, 1);
        add(1, 32'h6, 1, 0, 1, 1);
        add(0, 32'h0, 1, 0, 1, 1);
        add(0, 32'h0, 0, 0, 0, 1);

        foreach (vecs[i]) run_vec(vecs[i], i);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        // asynchronous reset mid-cycle with two entries held
        begin
            vec_t v;
            v.fv = 1; v.idr = 0; v.fl = 0; v.exp_fr = 1;
            v.pc = 32'h200; v.instr = mk_instr(32'h200); v.exp_cnt = 0;
            run_vec(v, 100);
            v.pc = 32'h204; v.instr = mk_instr(32'h204); v.exp_cnt = 1;
            run_vec(v, 101);
        end
        fetch_valid = 1'b0;
        chk("pre_arst.count", 32'(count), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.count",       32'(count),       32'd0);
        chk("arst.id_valid",    32'(id_valid),    32'd0);
        chk("arst.id_instr",    id_instr,         NOP);
        chk("arst.fetch_ready", 32'(fetch_ready), 32'd1);
        sb.delete();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_arst.count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
